// File: rtl/round_robin_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Build option: ROUND_ROBIN_ARBITER_LOCK_EN enables the multi-beat lock FSM.
package round_robin_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Explicit wrap so non-power-of-two widths never land on an unused index.
  function automatic int unsigned ptr_inc(input int unsigned idx, input int unsigned width);
    return (idx + 1 >= width) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Grant outputs are combinational from requests and the registered pointer.
interface round_robin_arbiter_if #(
  parameter int WIDTH = 4
) ();
  localparam int WIDTH_LOG = $clog2(WIDTH);

  logic [WIDTH-1:0]     req_vld;
  logic [WIDTH-1:0]     req_lst;
  logic                 gnt_rdy;
  logic                 gnt_vld;
  logic [WIDTH_LOG-1:0] gnt_idx;
  logic [WIDTH-1:0]     gnt_oht;
  logic [WIDTH_LOG-1:0] gnt_ptr;

  modport master (
    output req_vld, req_lst, gnt_rdy,
    input  gnt_vld, gnt_idx, gnt_oht, gnt_ptr
  );

  modport slave (
    input  req_vld, req_lst, gnt_rdy,
    output gnt_vld, gnt_idx, gnt_oht, gnt_ptr
  );
endinterface

// File: rtl/round_robin_arbiter_ppe.sv
// Programmable priority encoder: first set request at or above enc_pri, wrapping to 0.
// High class beats low class; each class is scanned as a SPLIT-wide two-level tree.
module programmable_priority_encoder #(
  parameter  int WIDTH     = 4,
  parameter  int SPLIT     = 2,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     dec_vld_h,
  input  logic [WIDTH-1:0]     dec_vld_l,
  input  logic [WIDTH_LOG-1:0] enc_pri,
  output logic [WIDTH_LOG-1:0] enc_idx_h,
  output logic                 enc_vld_h
);
  localparam int GRP = (WIDTH + SPLIT - 1) / SPLIT;

  // Returns {found, index of lowest set bit}.
  function automatic logic [WIDTH_LOG:0] ffs(input logic [WIDTH-1:0] v);
    logic [GRP-1:0]       any;
    logic [WIDTH_LOG-1:0] idx;
    int                   sel;
    any = '0;
    idx = '0;
    sel = 0;
    for (int g = 0; g < GRP; g++)
      for (int b = 0; b < SPLIT; b++)
        if (g * SPLIT + b < WIDTH) any[g] = any[g] | v[g * SPLIT + b];
    for (int g = GRP - 1; g >= 0; g--)
      if (any[g]) sel = g;
    for (int b = SPLIT - 1; b >= 0; b--)
      if (sel * SPLIT + b < WIDTH && v[sel * SPLIT + b]) idx = WIDTH_LOG'(sel * SPLIT + b);
    return {|any, idx};
  endfunction

  logic [WIDTH-1:0]   w_mask;
  logic [WIDTH_LOG:0] w_h_hi, w_h_all, w_l_hi, w_l_all;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < WIDTH; i++) w_mask[i] = (32'(i) >= 32'(enc_pri));
  end

  assign w_h_hi  = ffs(dec_vld_h & w_mask);
  assign w_h_all = ffs(dec_vld_h);
  assign w_l_hi  = ffs(dec_vld_l & w_mask);
  assign w_l_all = ffs(dec_vld_l);

  always_comb begin
    enc_vld_h = w_h_all[WIDTH_LOG] | w_l_all[WIDTH_LOG];
    if (w_h_all[WIDTH_LOG])
      enc_idx_h = w_h_hi[WIDTH_LOG] ? w_h_hi[WIDTH_LOG-1:0] : w_h_all[WIDTH_LOG-1:0];
    else
      enc_idx_h = w_l_hi[WIDTH_LOG] ? w_l_hi[WIDTH_LOG-1:0] : w_l_all[WIDTH_LOG-1:0];
  end
endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter, zero-latency grant, pointer advances after each completed transfer.
// ROUND_ROBIN_ARBITER_LOCK_EN: holds the grant on one requester until its last beat.
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SPLIT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  round_robin_arbiter_if.slave   bus
);
  localparam int WIDTH_LOG = $clog2(WIDTH);

  logic [WIDTH_LOG-1:0] r_ptr;
  logic [WIDTH_LOG-1:0] w_enc_idx;
  logic                 w_enc_vld;
  logic [WIDTH_LOG-1:0] w_idx;
  logic                 w_vld;
  logic                 w_xfer;
  logic [WIDTH_LOG-1:0] w_ptr_nxt;

  programmable_priority_encoder #(
    .WIDTH (WIDTH),
    .SPLIT (SPLIT)
  ) u_ppe (
    .dec_vld_h (bus.req_vld),
    .dec_vld_l ('0),
    .enc_pri   (r_ptr),
    .enc_idx_h (w_enc_idx),
    .enc_vld_h (w_enc_vld)
  );

  assign w_xfer    = w_vld & bus.gnt_rdy;
  assign w_ptr_nxt = WIDTH_LOG'(ptr_inc(32'(w_idx), WIDTH));

`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
  arb_state_t           r_state;
  logic [WIDTH_LOG-1:0] r_lck;

  // While locked, other requesters are invisible even if the owner drops its request.
  assign w_idx = (r_state == LOCK) ? r_lck : w_enc_idx;
  assign w_vld = (r_state == LOCK) ? bus.req_vld[r_lck] : w_enc_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_lck   <= '0;
      r_state <= IDLE;
    end else if (w_xfer) begin
      if (bus.req_lst[w_idx]) begin
        r_ptr   <= w_ptr_nxt;
        r_state <= IDLE;
      end else begin
        r_lck   <= w_idx;
        r_state <= LOCK;
      end
    end
  end
`else
  logic w_unused_lst;

  assign w_unused_lst = ^bus.req_lst;
  assign w_idx        = w_enc_idx;
  assign w_vld        = w_enc_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ptr <= '0;
    else if (w_xfer)
      r_ptr <= w_ptr_nxt;
  end
`endif

  always_comb begin
    bus.gnt_oht = '0;
    if (w_vld) bus.gnt_oht[w_idx] = 1'b1;
  end

  assign bus.gnt_vld = w_vld;
  assign bus.gnt_idx = w_idx;
  assign bus.gnt_ptr = r_ptr;
endmodule
